argmax_cmp_pipe: RTL and testbench
==================================

Name: argmax_cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-pair 3-bit greater-than comparator used in the TNN classifier output stage.
- Takes NCH class scores of WIDTH bits each and reduces them through a registered binary comparator tree.
- Outputs the winning index, the maximum score and a tie flag.
- Uses a valid/ready handshake with full backpressure, so it can sit directly between the TNN column accumulators and the result interface.

Parameters:
- WIDTH, 3, bit width of each score.
- NCH, 8, number of channels (scores); any value 2..64, need not be a power of two.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- IDXW, $clog2(NCH), width of the winner index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_scores  in  NCH*WIDTH  packed scores; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  IDXW  index of the winning channel.
- out_max  out  WIDTH  winning score.
- out_tie  out  1  1 if at least one other channel equals out_max.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). While rst is high, all stage valid bits clear; out_valid=0, out_idx=0, out_max=0, out_tie=0. in_ready=1 in the first cycle after reset.
- Tree: L = $clog2(NCH) levels, one register stage per level. Level 0 pairs channels (2j, 2j+1). An odd leftover node at any level passes through unchanged into the next level's register. Each node carries {valid, idx, score, tie}.
- Node compare: left = lower-index operand.
  - Winner = right if right.score > left.score (strict; signed or unsigned per SIGNED); otherwise left. Equal scores pick the lower index.
  - tie_out = (left.score == right.score) | winner.tie.
  - A tie that exists only in a losing subtree does not propagate, because it is below the max.
- Latency: an accepted vector appears on out_* exactly L cycles later when there is no stall. Throughput is 1 vector per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall=1, every stage register holds, including bubbles.
  - When stall=0, all stages advance; stage 0 loads in_valid & in_ready.
  - A transfer occurs on in_valid & in_ready, and on out_valid & out_ready.
- Bubbles: stages with valid=0 advance freely. out_valid reflects the last stage's valid bit.
- out_* data is held stable while out_valid=1 and out_ready=0.
- in_scores is sampled only on an accepted cycle. The value of in_scores when in_valid=0 has no effect.
- Reset mid-operation: all in-flight vectors are discarded; no partial result is emitted after rst deasserts.
- Boundaries:
  - NCH=2 gives L=1.
  - All-equal scores give idx=0, tie=1.
  - With SIGNED=1, the most negative value (100 for WIDTH=3) loses to all other values.
  - With SIGNED=0, 111 beats all other values.

Test Plan:
- Reset/idle: assert rst 2 cycles, in_valid=0 → out_valid=0, out_idx=0, out_max=0, out_tie=0, in_ready=1.
- Basic argmax (WIDTH=3, NCH=8, unsigned): scores ch0..7 = 1,3,2,7,0,5,6,4, out_ready=1 → after 3 cycles out_valid=1, out_idx=3, out_max=7, out_tie=0.
- Tie handling: scores 2,6,1,6,0,3,6,5 → out_idx=1, out_max=6, out_tie=1. Scores 5,5,0,7,... (no other 7) → out_idx=3, out_tie=0, since the losing-subtree tie is not propagated.
- Signed mode (SIGNED=1): scores 100,111,011,000,... → out_idx=2, out_max=011. Non-power-of-two check with NCH=5: scores 0,1,2,3,6 → out_idx=4, latency 3.
- Backpressure: stream 6 back-to-back vectors, hold out_ready=0 for 4 cycles mid-stream → in_ready drops the same cycle stall asserts, no vector is lost or duplicated, results arrive in order, and out_* stays stable during the stall.
- Reset mid-flight: accept 2 vectors, assert rst for 1 cycle → out_valid stays 0 afterwards until new input. The first post-reset vector emerges after L cycles with the correct result.

Source files
------------

// File: rtl/argmax_cmp_pipe.sv
// Pipelined argmax over NCH scores: one registered compare level per tree level.
// Equal scores resolve to the lower index; out_tie flags a repeated maximum.
module argmax_cmp_pipe #(
  parameter int WIDTH  = 3,
  parameter int NCH    = 8,
  parameter int SIGNED = 0,
  parameter int IDXW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_scores,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_idx,
  output logic [WIDTH-1:0]     out_max,
  output logic                 out_tie
);

  localparam int L = $clog2(NCH);

  function automatic int cnt_at(input int lvl);
    int c;
    c = NCH;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int off_at(input int lvl);
    int s;
    s = 0;
    for (int i = 0; i < lvl; i++) s += cnt_at(i);
    return s;
  endfunction

  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Registered nodes of all stages, stage 0 first; the last node is the result.
  localparam int TQ = off_at(L + 1) - NCH;

  logic                 stall;
  logic [L-1:0]         vld_q, vld_d;
  logic [TQ*WIDTH-1:0]  sc_q, sc_d, cmp_sc, msk_sc;
  logic [TQ*IDXW-1:0]   idx_q, idx_d, cmp_idx, msk_idx;
  logic [TQ-1:0]        tie_q, tie_d, cmp_tie, ld;

  assign out_valid = vld_q[L-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_max   = sc_q[(TQ-1)*WIDTH +: WIDTH];
  assign out_idx   = idx_q[(TQ-1)*IDXW +: IDXW];
  assign out_tie   = tie_q[TQ-1];

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NI = cnt_at(l);
    localparam int NO = cnt_at(l + 1);
    localparam int BI = off_at(l) - NCH;
    localparam int BO = off_at(l + 1) - NCH;

    for (genvar j = 0; j < NO; j++) begin : g_node
      localparam int LQ = BI + 2 * j;
      localparam int O  = BO + j;

      logic [WIDTH-1:0] a_sc;
      logic [IDXW-1:0]  a_idx;
      logic             a_tie;

      if (l == 0) begin : g_a
        assign a_sc  = in_scores[(2*j)*WIDTH +: WIDTH];
        assign a_idx = IDXW'(2 * j);
        assign a_tie = 1'b0;
        assign ld[O] = in_valid;
      end else begin : g_a
        assign a_sc  = sc_q[LQ*WIDTH +: WIDTH];
        assign a_idx = idx_q[LQ*IDXW +: IDXW];
        assign a_tie = tie_q[LQ];
        assign ld[O] = vld_q[l-1];
      end

      assign msk_sc[O*WIDTH +: WIDTH] = {WIDTH{ld[O]}};
      assign msk_idx[O*IDXW +: IDXW]  = {IDXW{ld[O]}};

      if (2 * j + 1 < NI) begin : g_cmp
        logic [WIDTH-1:0] b_sc;
        logic [IDXW-1:0]  b_idx;
        logic             b_tie;
        logic             b_win;

        if (l == 0) begin : g_b
          assign b_sc  = in_scores[(2*j+1)*WIDTH +: WIDTH];
          assign b_idx = IDXW'(2 * j + 1);
          assign b_tie = 1'b0;
        end else begin : g_b
          assign b_sc  = sc_q[(LQ+1)*WIDTH +: WIDTH];
          assign b_idx = idx_q[(LQ+1)*IDXW +: IDXW];
          assign b_tie = tie_q[LQ+1];
        end

        // Only a strictly larger right operand wins, so equal scores keep the lower index.
        assign b_win = gt(b_sc, a_sc);
        assign cmp_sc[O*WIDTH +: WIDTH] = b_win ? b_sc : a_sc;
        assign cmp_idx[O*IDXW +: IDXW]  = b_win ? b_idx : a_idx;
        assign cmp_tie[O] = (a_sc == b_sc) | (b_win ? b_tie : a_tie);
      end else begin : g_pass
        assign cmp_sc[O*WIDTH +: WIDTH] = a_sc;
        assign cmp_idx[O*IDXW +: IDXW]  = a_idx;
        assign cmp_tie[O] = a_tie;
      end
    end
  end

  // Data only loads behind a valid token, so idle inputs never disturb held results.
  always_comb begin
    vld_d = vld_q;
    sc_d  = sc_q;
    idx_d = idx_q;
    tie_d = tie_q;
    if (!stall) begin
      vld_d = L'({vld_q, in_valid});
      sc_d  = (sc_q & ~msk_sc) | (cmp_sc & msk_sc);
      idx_d = (idx_q & ~msk_idx) | (cmp_idx & msk_idx);
      tie_d = (tie_q & ~ld) | (cmp_tie & ld);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sc_q  <= '0;
      idx_q <= '0;
      tie_q <= '0;
    end else begin
      vld_q <= vld_d;
      sc_q  <= sc_d;
      idx_q <= idx_d;
      tie_q <= tie_d;
    end
  end

endmodule

// File: tb/tb_argmax_cmp_pipe.sv
// Bench for argmax_cmp_pipe: unsigned NCH=8, signed NCH=8 and unsigned NCH=5 instances
// driven in lockstep, checked by directed tables and a linear-scan scoreboard.
module tb_argmax_cmp_pipe;

  typedef struct {
    int         idx;
    logic [2:0] mx;
    bit         tie;
  } res_t;

  typedef struct {
    logic [23:0] sc;
    int          dut;
    int          e_idx;
    logic [2:0]  e_max;
    bit          e_tie;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [23:0] in_scores;
  logic [2:0]  rdy;
  logic [2:0]  o_vld;
  logic [2:0]  o_tie;
  logic [2:0]  o_idx [3];
  logic [2:0]  o_max [3];

  int   n_pass  = 0;
  int   n_total = 0;
  res_t q_u8[$];
  res_t q_s8[$];
  res_t q_n5[$];
  bit         hold_p [3];
  logic [2:0] h_idx [3];
  logic [2:0] h_max [3];
  logic       h_tie [3];
  int         n_out [3];
  vec_t       tbl [11];

  always #5 clk = ~clk;

  argmax_cmp_pipe #(.WIDTH(3), .NCH(8), .SIGNED(0)) u_u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_scores(in_scores),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_idx(o_idx[0]), .out_max(o_max[0]),
    .out_tie(o_tie[0]));

  argmax_cmp_pipe #(.WIDTH(3), .NCH(8), .SIGNED(1)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_scores(in_scores),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_idx(o_idx[1]), .out_max(o_max[1]),
    .out_tie(o_tie[1]));

  argmax_cmp_pipe #(.WIDTH(3), .NCH(5), .SIGNED(0)) u_n5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_scores(in_scores[14:0]),
    .out_valid(o_vld[2]), .out_ready(out_ready), .out_idx(o_idx[2]), .out_max(o_max[2]),
    .out_tie(o_tie[2]));

  function automatic string dn(input int d);
    case (d)
      0:       return "u8";
      1:       return "s8";
      default: return "n5";
    endcase
  endfunction

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Reference: linear scan for the first maximum, tie when the maximum occurs more than once.
  function automatic res_t model(input logic [23:0] sc, input int nch, input bit sgn);
    res_t r;
    int   best;
    int   v;
    int   cnt;
    best  = -100;
    r.idx = 0;
    for (int k = 0; k < nch; k++) begin
      v = int'(sc[k*3 +: 3]);
      if (sgn && v >= 4) v -= 8;
      if (v > best) begin
        best  = v;
        r.idx = k;
      end
    end
    cnt = 0;
    for (int k = 0; k < nch; k++) begin
      v = int'(sc[k*3 +: 3]);
      if (sgn && v >= 4) v -= 8;
      if (v == best) cnt++;
    end
    r.mx  = best[2:0];
    r.tie = (cnt > 1);
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input string got, input string exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, got, exp);
  endtask

  task automatic sb_push(input int d, input res_t r);
    case (d)
      0:       q_u8.push_back(r);
      1:       q_s8.push_back(r);
      default: q_n5.push_back(r);
    endcase
  endtask

  task automatic sb_pop(input int d, output res_t r, output bit ok);
    ok    = 1'b1;
    r.idx = 0;
    r.mx  = 3'd0;
    r.tie = 1'b0;
    case (d)
      0:       if (q_u8.size() == 0) ok = 1'b0; else r = q_u8.pop_front();
      1:       if (q_s8.size() == 0) ok = 1'b0; else r = q_s8.pop_front();
      default: if (q_n5.size() == 0) ok = 1'b0; else r = q_n5.pop_front();
    endcase
  endtask

  function automatic string outs(input int d);
    return $sformatf("v=%0b idx=%0d max=%0d tie=%0b", o_vld[d], o_idx[d], o_max[d], o_tie[d]);
  endfunction

  // One clock: observe handshakes mid-cycle, then return just after the rising edge.
  task automatic cyc();
    res_t r;
    bit   ok;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        hold_p[d] = 1'b0;
      end else begin
        if (hold_p[d])
          chk(o_vld[d] && o_idx[d] == h_idx[d] && o_max[d] == h_max[d] && o_tie[d] == h_tie[d],
              {"hold_", dn(d)}, outs(d),
              $sformatf("v=1 idx=%0d max=%0d tie=%0b", h_idx[d], h_max[d], h_tie[d]));
        if (in_valid && rdy[d])
          sb_push(d, model(in_scores, (d == 2) ? 5 : 8, d == 1));
        if (o_vld[d] && out_ready) begin
          sb_pop(d, r, ok);
          n_out[d]++;
          chk(ok && int'(o_idx[d]) == r.idx && o_max[d] == r.mx && o_tie[d] == r.tie,
              {"sb_", dn(d)}, outs(d),
              ok ? $sformatf("idx=%0d max=%0d tie=%0b", r.idx, r.mx, r.tie) : "no output pending");
        end
        hold_p[d] = o_vld[d] && !out_ready;
        h_idx[d]  = o_idx[d];
        h_max[d]  = o_max[d];
        h_tie[d]  = o_tie[d];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int          d;
    int          sent;
    int          stall_cnt;
    int          base;
    bit          acc;
    logic [23:0] bp [6];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_scores = '0;
    for (int i = 0; i < 3; i++) begin
      hold_p[i] = 1'b0;
      n_out[i]  = 0;
    end

    tbl[0]  = '{pk(1,3,2,7,0,5,6,4), 0, 3, 3'd7, 1'b0};
    tbl[1]  = '{pk(2,6,1,6,0,3,6,5), 0, 1, 3'd6, 1'b1};
    tbl[2]  = '{pk(5,5,0,7,1,2,3,4), 0, 3, 3'd7, 1'b0};
    tbl[3]  = '{pk(3,3,3,3,3,3,3,3), 0, 0, 3'd3, 1'b1};
    tbl[4]  = '{pk(6,6,6,6,6,6,6,7), 0, 7, 3'd7, 1'b0};
    tbl[5]  = '{pk(4,7,3,0,1,2,5,6), 1, 2, 3'd3, 1'b0};
    tbl[6]  = '{pk(4,4,4,4,4,5,4,4), 1, 5, 3'd5, 1'b0};
    tbl[7]  = '{pk(4,4,4,4,4,4,4,4), 1, 0, 3'd4, 1'b1};
    tbl[8]  = '{pk(0,1,2,3,6,7,7,7), 2, 4, 3'd6, 1'b0};
    tbl[9]  = '{pk(6,1,2,3,6,0,0,0), 2, 0, 3'd6, 1'b1};
    tbl[10] = '{pk(7,1,2,3,6,0,0,0), 2, 0, 3'd7, 1'b0};

    // Reset and idle
    cyc();
    cyc();
    for (int i = 0; i < 3; i++)
      chk(!o_vld[i] && o_idx[i] == 3'd0 && o_max[i] == 3'd0 && !o_tie[i] && rdy[i],
          {"reset_", dn(i)}, {outs(i), $sformatf(" rdy=%0b", rdy[i])}, "v=0 idx=0 max=0 tie=0 rdy=1");
    rst = 1'b0;
    cyc();
    chk(rdy == 3'b111 && o_vld == 3'b000, "idle_after_reset",
        $sformatf("rdy=%b vld=%b", rdy, o_vld), "rdy=111 vld=000");

    // Directed vectors with latency check
    for (int i = 0; i < 11; i++) begin
      d         = tbl[i].dut;
      in_scores = tbl[i].sc;
      in_valid  = 1'b1;
      cyc();
      in_valid  = 1'b0;
      cyc();
      chk(!o_vld[d], $sformatf("lat_early_%0d", i), outs(d), "v=0");
      cyc();
      chk(o_vld[d] && int'(o_idx[d]) == tbl[i].e_idx && o_max[d] == tbl[i].e_max &&
          o_tie[d] == tbl[i].e_tie, $sformatf("vec_%0d_%s", i, dn(d)), outs(d),
          $sformatf("v=1 idx=%0d max=%0d tie=%0b", tbl[i].e_idx, tbl[i].e_max, tbl[i].e_tie));
    end
    cyc();

    // Back-to-back stream with a 4-cycle output stall
    for (int i = 0; i < 6; i++) bp[i] = 24'($urandom);
    sent      = 0;
    stall_cnt = 0;
    base      = n_out[0];
    for (int c = 0; c < 40; c++) begin
      if (sent == 6 && q_u8.size() == 0) break;
      out_ready = !(c >= 5 && c < 9);
      in_valid  = (sent < 6);
      if (sent < 6) in_scores = bp[sent];
      #1;
      if (o_vld[0] && !out_ready) begin
        stall_cnt++;
        chk(!rdy[0], "in_ready_stall", $sformatf("%0b", rdy[0]), "0");
      end else begin
        chk(rdy[0], "in_ready_free", $sformatf("%0b", rdy[0]), "1");
      end
      acc = in_valid && rdy[0];
      cyc();
      if (acc) sent++;
    end
    chk(sent == 6 && n_out[0] - base == 6 && q_u8.size() == 0, "bp_count",
        $sformatf("sent=%0d out=%0d pend=%0d", sent, n_out[0] - base, q_u8.size()),
        "sent=6 out=6 pend=0");
    chk(stall_cnt == 4, "bp_stall_cycles", $sformatf("%0d", stall_cnt), "4");

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_scores = 24'($urandom);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q_u8.size() + q_s8.size() + q_n5.size()) != 0; c++) cyc();
    chk(q_u8.size() + q_s8.size() + q_n5.size() == 0, "drain_random",
        $sformatf("pending=%0d", q_u8.size() + q_s8.size() + q_n5.size()), "pending=0");

    // Reset with two vectors in flight
    in_valid  = 1'b1;
    in_scores = pk(7,0,0,0,0,0,0,0);
    cyc();
    in_scores = pk(0,0,0,0,0,0,0,7);
    cyc();
    in_valid = 1'b0;
    rst      = 1'b1;
    cyc();
    rst = 1'b0;
    q_u8.delete();
    q_s8.delete();
    q_n5.delete();
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk(o_vld == 3'b000, $sformatf("rst_discard_%0d", c), $sformatf("vld=%b", o_vld), "vld=000");
    end
    in_scores = pk(2,6,1,6,0,3,6,5);
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk(o_vld == 3'b000, "post_rst_early", $sformatf("vld=%b", o_vld), "vld=000");
    cyc();
    chk(o_vld == 3'b111 && o_idx[0] == 3'd1 && o_max[0] == 3'd6 && o_tie[0], "post_rst_result",
        $sformatf("vld=%b %s", o_vld, outs(0)), "vld=111 idx=1 max=6 tie=1");
    cyc();
    chk(q_u8.size() + q_s8.size() + q_n5.size() == 0, "post_rst_drain",
        $sformatf("pending=%0d", q_u8.size() + q_s8.size() + q_n5.size()), "pending=0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
